// File: rtl/dft_12.sv
// 12-point DFT accumulation engine: walks every (k,n) pair and sums the products
// returned on i_re/i_im into one X[k] per bin, publishing each bin with a done pulse.
module dft_12 #(
    parameter int N  = 12,
    parameter int IW = 16,
    parameter int OW = IW + 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] i_re,
    input  logic [IW-1:0] i_im,
    input  logic          i_start,
    output logic [4:0]    o_k,
    output logic [4:0]    o_n,
    output logic [OW-1:0] o_re,
    output logic [OW-1:0] o_im,
    output logic          o_done_one,
    output logic          o_done_all,
    output logic          o_valid
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [4:0] LAST = 5'(N - 1);

    state_t        state_r, state_s;
    logic [4:0]    k_r, k_s;
    logic [4:0]    n_r, n_s;
    logic [OW-1:0] acc_re_r, acc_re_s;
    logic [OW-1:0] acc_im_r, acc_im_s;
    logic [OW-1:0] re_r, re_s;
    logic [OW-1:0] im_r, im_s;
    logic [OW-1:0] sum_re_s, sum_im_s;
    logic          done_one_r, done_one_s;
    logic          done_all_r, done_all_s;
    logic          valid_r, valid_s;

    // Next-state, counter and accumulator logic for the sweep.
    always_comb begin
        state_s    = state_r;
        k_s        = k_r;
        n_s        = n_r;
        acc_re_s   = acc_re_r;
        acc_im_s   = acc_im_r;
        re_s       = re_r;
        im_s       = im_r;
        done_one_s = 1'b0;
        done_all_s = 1'b0;
        valid_s    = valid_r;
        sum_re_s   = acc_re_r + {{(OW-IW){i_re[IW-1]}}, i_re};
        sum_im_s   = acc_im_r + {{(OW-IW){i_im[IW-1]}}, i_im};
        case (state_r)
            ST_IDLE: begin
                // A start landing on the final-bin pulse cycle is dropped.
                if (i_start && !done_all_r) begin
                    state_s  = ST_RUN;
                    k_s      = 5'd0;
                    n_s      = 5'd0;
                    acc_re_s = '0;
                    acc_im_s = '0;
                    valid_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (n_r == LAST) begin
                    re_s       = sum_re_s;
                    im_s       = sum_im_s;
                    acc_re_s   = '0;
                    acc_im_s   = '0;
                    n_s        = 5'd0;
                    done_one_s = 1'b1;
                    if (k_r == LAST) begin
                        state_s    = ST_IDLE;
                        k_s        = 5'd0;
                        valid_s    = 1'b0;
                        done_all_s = 1'b1;
                    end else begin
                        k_s = k_r + 5'd1;
                    end
                end else begin
                    acc_re_s = sum_re_s;
                    acc_im_s = sum_im_s;
                    n_s      = n_r + 5'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                k_s     = 5'd0;
                n_s     = 5'd0;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            k_r        <= 5'd0;
            n_r        <= 5'd0;
            acc_re_r   <= '0;
            acc_im_r   <= '0;
            re_r       <= '0;
            im_r       <= '0;
            done_one_r <= 1'b0;
            done_all_r <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            k_r        <= k_s;
            n_r        <= n_s;
            acc_re_r   <= acc_re_s;
            acc_im_r   <= acc_im_s;
            re_r       <= re_s;
            im_r       <= im_s;
            done_one_r <= done_one_s;
            done_all_r <= done_all_s;
            valid_r    <= valid_s;
        end
    end

    assign o_k        = k_r;
    assign o_n        = n_r;
    assign o_re       = re_r;
    assign o_im       = im_r;
    assign o_done_one = done_one_r;
    assign o_done_all = done_all_r;
    assign o_valid    = valid_r;

endmodule

// File: tb/tb_dft_12.sv
// Self-checking bench for dft_12: constant-input vector table, random sweeps against
// a summing model, a trig-based DFT check, mid-sweep start and mid-sweep reset.
module tb_dft_12;

    localparam int N  = 12;
    localparam int IW = 16;
    localparam int OW = 28;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] i_re, i_im;
    logic          i_start;
    logic [4:0]    o_k, o_n;
    logic [OW-1:0] o_re, o_im;
    logic          o_done_one, o_done_all, o_valid;

    always #5 clk = ~clk;

    dft_12 #(.N(N), .IW(IW), .OW(OW)) dut (
        .clk(clk), .rst(rst), .i_re(i_re), .i_im(i_im), .i_start(i_start),
        .o_k(o_k), .o_n(o_n), .o_re(o_re), .o_im(o_im),
        .o_done_one(o_done_one), .o_done_all(o_done_all), .o_valid(o_valid)
    );

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        longint      exp_re;
        longint      exp_im;
    } vec_t;

    vec_t        vecs[5];
    logic [15:0] xr[N][N];
    logic [15:0] xi[N][N];
    longint      eref_re[N];
    longint      eref_im[N];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp, input longint tol);
        longint d;
        d = act - exp;
        if (d < 0) d = -d;
        n_tests++;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " valid"}, longint'(o_valid), 0, 0);
        chk({tag, " k"}, longint'(o_k), 0, 0);
        chk({tag, " n"}, longint'(o_n), 0, 0);
        chk({tag, " re"}, longint'($signed(o_re)), 0, 0);
        chk({tag, " im"}, longint'($signed(o_im)), 0, 0);
        chk({tag, " done_one"}, longint'(o_done_one), 0, 0);
        chk({tag, " done_all"}, longint'(o_done_all), 0, 0);
    endtask

    // Sum model: X[k] is simply the sum of the twelve products of row k.
    task automatic model_sums();
        for (int k = 0; k < N; k++) begin
            eref_re[k] = 0;
            eref_im[k] = 0;
            for (int n = 0; n < N; n++) begin
                eref_re[k] += longint'($signed(xr[k][n]));
                eref_im[k] += longint'($signed(xi[k][n]));
            end
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++)
            for (int n = 0; n < N; n++) begin
                xr[k][n] = 16'($urandom);
                xi[k][n] = 16'($urandom);
            end
    endtask

    // One full sweep from IDLE; cycle c after the start edge addresses (c/12, c%12).
    task automatic run_sweep(input int mid_start, input string tag, input longint tol);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 0; c < N * N; c++) begin
            int  kk, nn;
            logic exp_done;
            kk = c / N;
            nn = c % N;
            exp_done = (c > 0) && (nn == 0);
            i_re = xr[kk][nn];
            i_im = xi[kk][nn];
            i_start = (c == mid_start);
            chk({tag, " valid"}, longint'(o_valid), 1, 0);
            chk({tag, " k"}, longint'(o_k), kk, 0);
            chk({tag, " n"}, longint'(o_n), nn, 0);
            chk({tag, " done_all"}, longint'(o_done_all), 0, 0);
            chk({tag, " done_one"}, longint'(o_done_one), longint'(exp_done), 0);
            if (exp_done) begin
                chk({tag, " bin re"}, longint'($signed(o_re)), eref_re[kk-1], tol);
                chk({tag, " bin im"}, longint'($signed(o_im)), eref_im[kk-1], tol);
            end
            step();
        end
        i_start = 1'b1;
        i_re    = 16'h0000;
        i_im    = 16'h0000;
        chk({tag, " last done_one"}, longint'(o_done_one), 1, 0);
        chk({tag, " last done_all"}, longint'(o_done_all), 1, 0);
        chk({tag, " last valid"}, longint'(o_valid), 0, 0);
        chk({tag, " last k"}, longint'(o_k), 0, 0);
        chk({tag, " last n"}, longint'(o_n), 0, 0);
        chk({tag, " last re"}, longint'($signed(o_re)), eref_re[N-1], tol);
        chk({tag, " last im"}, longint'($signed(o_im)), eref_im[N-1], tol);
        step();
        i_start = 1'b0;
        chk({tag, " start on done_all ignored"}, longint'(o_valid), 0, 0);
        chk({tag, " done_one cleared"}, longint'(o_done_one), 0, 0);
        chk({tag, " done_all cleared"}, longint'(o_done_all), 0, 0);
        chk({tag, " hold re"}, longint'($signed(o_re)), eref_re[N-1], tol);
        chk({tag, " hold im"}, longint'($signed(o_im)), eref_im[N-1], tol);
    endtask

    initial begin
        real pi, th, x_r, x_i;
        int  qa[N];
        pi      = 3.14159265358979;
        rst     = 1'b1;
        i_start = 1'b0;
        i_re    = 16'h0000;
        i_im    = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle valid", longint'(o_valid), 0, 0);
            chk("idle done_one", longint'(o_done_one), 0, 0);
        end

        vecs[0] = '{16'h7FFF, 16'h0000, 393204, 0};
        vecs[1] = '{16'h7FFF, 16'h8000, 393204, -393216};
        vecs[2] = '{16'h8000, 16'h7FFF, -393216, 393204};
        vecs[3] = '{16'hFFFF, 16'h0001, -12, 12};
        vecs[4] = '{16'h1234, 16'hFEDC, 55920, -3504};
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < N; k++) begin
                eref_re[k] = vecs[v].exp_re;
                eref_im[k] = vecs[v].exp_im;
                for (int n = 0; n < N; n++) begin
                    xr[k][n] = vecs[v].re;
                    xi[k][n] = vecs[v].im;
                end
            end
            run_sweep((v == 0) ? 50 : -1, $sformatf("vec%0d", v), 0);
        end

        for (int r = 0; r < 3; r++) begin
            fill_random();
            model_sums();
            run_sweep(-1, $sformatf("rand%0d", r), 0);
        end

        // QPSK symbols rotated by the 12-point twiddles; reference is the ideal real DFT.
        for (int n = 0; n < N; n++) qa[n] = int'($urandom_range(0, 3));
        for (int k = 0; k < N; k++) begin
            eref_re[k] = 0;
            eref_im[k] = 0;
            x_r = 0.0;
            x_i = 0.0;
            for (int n = 0; n < N; n++) begin
                th = pi / 4.0 + real'(qa[n]) * pi / 2.0 - 2.0 * pi * real'(k * n) / 12.0;
                xr[k][n] = 16'(int'(32767.0 * $cos(th)));
                xi[k][n] = 16'(int'(32767.0 * $sin(th)));
                x_r += 32767.0 * $cos(th);
                x_i += 32767.0 * $sin(th);
            end
            eref_re[k] = longint'(x_r);
            eref_im[k] = longint'(x_i);
        end
        run_sweep(-1, "dft", 12);

        fill_random();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 0; c < 70; c++) begin
            i_re = xr[c / N][c % N];
            i_im = xi[c / N][c % N];
            step();
        end
        #2 rst = 1'b1;
        #1;
        chk_idle_zero("async rst");
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            chk("post rst valid", longint'(o_valid), 0, 0);
            chk("post rst done_one", longint'(o_done_one), 0, 0);
            chk("post rst done_all", longint'(o_done_all), 0, 0);
            step();
        end
        model_sums();
        run_sweep(-1, "after rst", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
